// File: rtl/pkg_tpu.sv
// Shared TPU types for the vector command path: command word, issue number
// and the commit-report FSM state.
package pkg_tpu;

  localparam int NUM_ENTRY_HAZARD = 8;
  localparam int ISSUE_NO_W       = $clog2(NUM_ENTRY_HAZARD);

  typedef logic [ISSUE_NO_W-1:0] issue_no_t;

  typedef struct packed {
    logic       v;
    logic [6:0] opcode;
  } instr_t;

  typedef struct packed {
    instr_t     instr;
    issue_no_t  issue_no;
    logic [15:0] operand;
  } command_t;

  typedef enum logic {
    COMMIT_IDLE = 1'b0,
    COMMIT_SEND = 1'b1
  } commit_state_e;

endpackage

// File: rtl/vcmd_fifo.sv
// Parameterised synchronous FIFO with extended read/write pointers; reports
// occupancy so the owner derives empty/full. Used for commands and commits.
module vcmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full, empty, push_ok, pop_ok;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = i_pop && !empty;
    push_ok  = i_push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    o_data   = mem[rd_ptr_q[AW-1:0]];
    o_count  = wr_ptr_q - rd_ptr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone say which
  // entries are valid, so the array can map onto plain RAM or reset-less flops.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/vcmd_receiver.sv
// Vector command receiver: buffers scalar-unit commands, issues them to the
// lane, tracks outstanding issue numbers and reports commits. VCMD_BYPASS_EN adds an empty-FIFO bypass.
module vcmd_receiver
  import pkg_tpu::*;
#(
  parameter int DEPTH_CMD        = 4,
  parameter int NUM_ENTRY_HAZARD = pkg_tpu::NUM_ENTRY_HAZARD
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      I_Cmd_Valid,
  input  command_t  I_Cmd,
  output logic      O_Cmd_Ready,
  output logic      O_Issue_Valid,
  output command_t  O_Issue,
  input  logic      I_Lane_Stall,
  input  logic      I_Done_Valid,
  input  issue_no_t I_Done_No,
  output logic      O_Commit,
  output issue_no_t O_Commit_No,
  input  logic      I_Commit_Ack,
  output logic      O_Busy,
  output logic      O_Err
);

  localparam int CMD_CW = $clog2(DEPTH_CMD) + 1;
  localparam int HZ_CW  = $clog2(NUM_ENTRY_HAZARD) + 1;
  localparam logic [HZ_CW:0] HZ_LIMIT = (HZ_CW + 1)'(NUM_ENTRY_HAZARD);

  logic [CMD_CW-1:0] cmd_count;
  command_t          cmd_head, issue_src;
  logic              cmd_empty, cmd_full, cmd_push, cmd_pop, cmd_accept;
  logic              bypass, issue_take;

  issue_no_t         cq_head;
  logic [HZ_CW-1:0]  cq_count, out_cnt;
  logic [HZ_CW:0]    hazard_sum;
  logic              cq_push, cq_pop, cq_empty, hazard_full;

  logic [NUM_ENTRY_HAZARD-1:0] out_q, out_d;
  logic              err_q, err_d;
  logic              issue_valid_q, issue_valid_d;
  command_t          issue_q, issue_d;

  commit_state_e     state_q;
  logic              commit_q;
  issue_no_t         commit_no_q;

  vcmd_fifo #(.WIDTH($bits(command_t)), .DEPTH(DEPTH_CMD)) u_cmd_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (cmd_push),
    .i_data  (I_Cmd),
    .i_pop   (cmd_pop),
    .o_data  (cmd_head),
    .o_count (cmd_count)
  );

  vcmd_fifo #(.WIDTH($bits(issue_no_t)), .DEPTH(NUM_ENTRY_HAZARD)) u_commit_q (
    .clock   (clock),
    .reset   (reset),
    .i_push  (cq_push),
    .i_data  (I_Done_No),
    .i_pop   (cq_pop),
    .o_data  (cq_head),
    .o_count (cq_count)
  );

  always_comb begin
    cmd_empty = (cmd_count == '0);
    cmd_full  = (cmd_count == CMD_CW'(DEPTH_CMD));
    cmd_pop   = !cmd_empty && !I_Lane_Stall;
    cq_empty  = (cq_count == '0);

    out_cnt = '0;
    for (int i = 0; i < NUM_ENTRY_HAZARD; i++) out_cnt = out_cnt + HZ_CW'(out_q[i]);
    hazard_sum  = (HZ_CW + 1)'(out_cnt) + (HZ_CW + 1)'(cq_count);
    hazard_full = (hazard_sum >= HZ_LIMIT);

    O_Cmd_Ready = (!cmd_full || cmd_pop) && !hazard_full;
    cmd_accept  = I_Cmd_Valid && O_Cmd_Ready && I_Cmd.instr.v;
`ifdef VCMD_BYPASS_EN
    bypass = cmd_accept && cmd_empty && !I_Lane_Stall;
`else
    bypass = 1'b0;
`endif
    cmd_push   = cmd_accept && !bypass;
    issue_take = cmd_pop || bypass;
    issue_src  = cmd_pop ? cmd_head : I_Cmd;

    // NOTE: blocking assignments here are evaluated in order, which is what
    // makes a same-cycle completion clear its bit before a new issue sets it.
    out_d   = out_q;
    err_d   = err_q;
    cq_push = 1'b0;
    if (I_Done_Valid) begin
      if (out_q[I_Done_No]) begin
        out_d[I_Done_No] = 1'b0;
        cq_push          = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (issue_take) begin
      if (out_d[issue_src.issue_no]) err_d = 1'b1;
      out_d[issue_src.issue_no] = 1'b1;
    end

    issue_valid_d = issue_take;
    issue_d       = issue_take ? issue_src : issue_q;

    // The head is moved into the commit register as soon as it is presented.
    cq_pop = !cq_empty && ((state_q == COMMIT_IDLE) || I_Commit_Ack);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q         <= '0;
      err_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else begin
      out_q         <= out_d;
      err_q         <= err_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= COMMIT_IDLE;
      commit_q    <= 1'b0;
      commit_no_q <= '0;
    end else begin
      case (state_q)
        COMMIT_IDLE: begin
          if (!cq_empty) begin
            state_q     <= COMMIT_SEND;
            commit_q    <= 1'b1;
            commit_no_q <= cq_head;
          end
        end
        COMMIT_SEND: begin
          if (I_Commit_Ack) begin
            if (!cq_empty) begin
              commit_no_q <= cq_head;
            end else begin
              state_q  <= COMMIT_IDLE;
              commit_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= COMMIT_IDLE;
          commit_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_Issue_Valid = issue_valid_q;
  assign O_Issue       = issue_q;
  assign O_Commit      = commit_q;
  assign O_Commit_No   = commit_no_q;
  assign O_Err         = err_q;
  assign O_Busy        = !cmd_empty || (|out_q) || issue_valid_q ||
                         (state_q == COMMIT_SEND);

endmodule

// File: doc/vcmd_receiver.md
VCMD_RECEIVER -- requirements
Module: vcmd_receiver

Interface
REQ-001 SHALL have parameter DEPTH_CMD, default 4 (power of two, >=2): number of command FIFO entries.
REQ-002 SHALL have parameter NUM_ENTRY_HAZARD, default pkg_tpu value 8: issue_no space and outstanding-table size.
REQ-003 SHALL have port clock  in  1: sole clock, rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have ports I_Cmd_Valid  in  1, I_Cmd  in  command_t, O_Cmd_Ready  out  1: command from the scalar unit.
REQ-006 SHALL have ports O_Issue_Valid  out  1, O_Issue  out  command_t, I_Lane_Stall  in  1: issue into the lane pipeline.
REQ-007 SHALL have ports I_Done_Valid  in  1, I_Done_No  in  issue_no_t: lane write-back completion.
REQ-008 SHALL have ports O_Commit  out  1, O_Commit_No  out  issue_no_t, I_Commit_Ack  in  1: commit report to the scalar-unit commit_tab_v.
REQ-009 SHALL have ports O_Busy  out  1, O_Err  out  1: outstanding work present; protocol error sticky flag.

Function
REQ-010 Command accept SHALL occur when I_Cmd_Valid && O_Cmd_Ready; O_Cmd_Ready = FIFO not full, or full with a same-cycle pop.
REQ-011 Accepted commands with I_Cmd.instr.v=0 SHALL be discarded: not stored, no commit.
REQ-012 FIFO SHALL be DEPTH_CMD entries, read/write pointers WIDTH+1 bits; full when MSBs differ and low bits equal; wrap-around transparent.
REQ-013 Pop SHALL occur when FIFO non-empty and !I_Lane_Stall; O_Issue_Valid registered, 1 cycle after pop; O_Issue holds the popped command; O_Issue_Valid=0 and O_Issue held during stall.
REQ-014 On pop the outstanding bit [issue_no] SHALL be set; if already set, O_Err SHALL set and the command still issues.
REQ-015 I_Done_Valid SHALL clear outstanding bit [I_Done_No] and push I_Done_No to a commit queue of NUM_ENTRY_HAZARD entries; done on a clear bit SHALL set O_Err and be dropped.
REQ-016 Set and clear of the same bit in one cycle: clear (of the prior issue) SHALL apply first, then set.
REQ-017 Commit FSM states IDLE, SEND: IDLE->SEND when commit queue non-empty (O_Commit=1, O_Commit_No=head); SEND stays until I_Commit_Ack; on ack pop, then SEND if queue still non-empty else IDLE; O_Commit_No SHALL be stable while O_Commit=1.
REQ-018 Commit queue full: I_Lane_Stall-independent; the module SHALL deassert O_Cmd_Ready while outstanding count + queue count = NUM_ENTRY_HAZARD, so the queue cannot overflow.
REQ-019 O_Busy SHALL be 1 when FIFO non-empty, any outstanding bit set, O_Issue_Valid, or FSM in SEND.
REQ-020 Latency: accept at cycle N, empty FIFO, no stall -> O_Issue_Valid at N+2; done at M -> O_Commit at M+2.

Reset
REQ-021 reset SHALL asynchronously clear pointers, outstanding table, commit queue, O_Err; FSM to IDLE; O_Issue_Valid=0, O_Commit=0, O_Commit_No=0, O_Issue=0, O_Busy=0, O_Cmd_Ready=1 after release.
REQ-022 Reset mid-operation SHALL discard all queued commands and pending commits without emitting any.

Configuration
REQ-023 Macro VCMD_BYPASS_EN defined: when FIFO empty, !I_Lane_Stall and accept occurs, the command SHALL bypass the FIFO and issue at N+1; undefined: always via FIFO, N+2.

Structure
REQ-024 command_t, issue_no_t, NUM_ENTRY_HAZARD SHALL come from pkg_tpu; commit FSM state enum SHALL be added to pkg_tpu.
REQ-025 A sub-module vcmd_fifo (parameterised sync FIFO, width, depth) SHALL implement both command FIFO and commit queue.

Verification
REQ-026 Send issue_no 0..3, no stall -> O_Issue_Valid with 0,1,2,3 in order, first at N+2 (N+1 with VCMD_BYPASS_EN).
REQ-027 Stall held, send 5 commands, DEPTH_CMD=4 -> O_Cmd_Ready=0 after 4th; release -> all 5 issue in order.
REQ-028 Done 2 then 1, I_Commit_Ack held low 3 cycles -> O_Commit=1, O_Commit_No=2 stable 4 cycles, then 1.
REQ-029 Done for issue_no 5 never issued -> O_Err=1, no commit; reissue of outstanding issue_no 3 -> O_Err=1.
REQ-030 instr.v=0 command -> no issue, no commit, O_Busy stays 0.
REQ-031 Assert reset with 3 queued commands and 1 pending commit -> all outputs to reset values immediately, no later issue/commit.
